// File: rtl/knn_seq_pkg.sv
// Shared constants for the KNN distance-pass sequencer: state encodings and
// the default training-memory address width (also used by the sorter).
package knn_seq_pkg;

    localparam int KNN_N_W = 8;

    localparam logic [2:0] KNN_SEQ_IDLE  = 3'd0;
    localparam logic [2:0] KNN_SEQ_FETCH = 3'd1;
    localparam logic [2:0] KNN_SEQ_ISSUE = 3'd2;
    localparam logic [2:0] KNN_SEQ_DRAIN = 3'd3;
    localparam logic [2:0] KNN_SEQ_DONE  = 3'd4;

endpackage

// File: rtl/knn_seq_if.sv
// Register-side, training-memory and distance-datapath signals of the
// sequencer; master is the sequencer, slave is its environment.
interface knn_seq_if
    import knn_seq_pkg::*;
#(
    parameter int N_W = KNN_N_W
);
    logic           start;
    logic           abort;
    logic [N_W:0]   n_train;
    logic           mem_rd;
    logic [N_W-1:0] mem_addr;
    logic           dp_valid;
    logic           dp_ready;
    logic [N_W-1:0] dp_idx;
    logic           dp_last;
    logic           res_valid;
    logic           busy;
    logic           done;
    logic           err;

    modport master (
        input  start, abort, n_train, dp_ready, res_valid,
        output mem_rd, mem_addr, dp_valid, dp_idx, dp_last, busy, done, err
    );

    modport slave (
        output start, abort, n_train, dp_ready, res_valid,
        input  mem_rd, mem_addr, dp_valid, dp_idx, dp_last, busy, done, err
    );
endinterface

// File: rtl/knn_seq_cnt.sv
// Up-counter with synchronous clear and increment enable; clear wins.
module knn_seq_cnt #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk) begin
        if (rst || clr) q <= '0;
        else if (inc)   q <= q + ONE;
    end
endmodule

// File: rtl/knn_seq.sv
// Distance-pass sequencer: walks training memory, issues points to the
// distance datapath, counts returned results and pulses done.
module knn_seq
    import knn_seq_pkg::*;
#(
    parameter int N_W = KNN_N_W
) (
    input  logic      clk,
    input  logic      rst,
    knn_seq_if.master bus
);
    localparam logic [N_W:0] CNT_ONE = (N_W+1)'(1);

    logic [2:0]   state, state_nxt;
    logic [N_W:0] n_lat, issued, returned;
    logic         start_ok, res_ok, iss_inc, ret_inc, err_q;

    assign start_ok = (state == KNN_SEQ_IDLE) && bus.start;
    assign res_ok   = (state != KNN_SEQ_IDLE) && (returned < issued);
    // An aborted handshake is not a transfer, so issued holds.
    assign iss_inc  = (state == KNN_SEQ_ISSUE) && bus.dp_ready && !bus.abort;
    assign ret_inc  = bus.res_valid && res_ok;

    knn_seq_cnt #(.W(N_W+1)) u_issued (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .inc (iss_inc),
        .q   (issued)
    );

    knn_seq_cnt #(.W(N_W+1)) u_returned (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .inc (ret_inc),
        .q   (returned)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            KNN_SEQ_IDLE:
                if (bus.start)
                    state_nxt = (bus.n_train == '0) ? KNN_SEQ_DONE : KNN_SEQ_FETCH;
            KNN_SEQ_FETCH:
                state_nxt = KNN_SEQ_ISSUE;
            KNN_SEQ_ISSUE:
                if (bus.dp_ready)
                    state_nxt = (issued + CNT_ONE == n_lat) ? KNN_SEQ_DRAIN : KNN_SEQ_FETCH;
            KNN_SEQ_DRAIN:
                if (returned == n_lat) state_nxt = KNN_SEQ_DONE;
            KNN_SEQ_DONE:
                state_nxt = KNN_SEQ_IDLE;
            default:
                state_nxt = KNN_SEQ_IDLE;
        endcase
        if (state != KNN_SEQ_IDLE && bus.abort) state_nxt = KNN_SEQ_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= KNN_SEQ_IDLE;
            n_lat <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok)                     n_lat <= bus.n_train;
            if (start_ok)                     err_q <= 1'b0;
            else if (bus.res_valid && !res_ok) err_q <= 1'b1;
        end
    end

    // All outputs decode registered state only; dp_ready never reaches them.
    assign bus.busy     = (state != KNN_SEQ_IDLE);
    assign bus.mem_rd   = (state == KNN_SEQ_FETCH);
    assign bus.mem_addr = issued[N_W-1:0];
    assign bus.dp_valid = (state == KNN_SEQ_ISSUE);
    assign bus.dp_idx   = issued[N_W-1:0];
    assign bus.dp_last  = (state == KNN_SEQ_ISSUE) && (issued == n_lat - CNT_ONE);
    assign bus.done     = (state == KNN_SEQ_DONE);
    assign bus.err      = err_q;
endmodule

// File: tb/tb_knn_seq.sv
// Directed bench for knn_seq (N_W=3) with a pass-level reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_knn_seq;
    localparam int NW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    knn_seq_if #(.N_W(NW)) bus();
    knn_seq #(.N_W(NW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic res_auto = 1'b0, res_man = 1'b0;
    bit   auto_en = 1'b0;
    assign bus.res_valid = res_auto | res_man;

    int n_checks = 0, n_errors = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    bit sched [0:4095];

    // reference model: phase 0 idle, 1 fetch, 2 issue, 3 drain, 4 done
    int m_phase = 0, m_n = 0, m_iss = 0, m_ret = 0;
    bit m_err = 1'b0;

    int addr_q[$];
    int last_q[$];
    int done_cnt = 0, acc_cnt = 0, mrd_cnt = 0, idx1_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int nxt;
        bit ok;
        if (rst) begin
            m_phase = 0; m_n = 0; m_iss = 0; m_ret = 0; m_err = 1'b0;
            return;
        end
        nxt = m_phase;
        ok  = (m_phase != 0) && (m_ret < m_iss);
        case (m_phase)
            0: if (bus.start) nxt = (bus.n_train == 0) ? 4 : 1;
            1: nxt = 2;
            2: if (bus.dp_ready) nxt = (m_iss + 1 == m_n) ? 3 : 1;
            3: if (m_ret == m_n) nxt = 4;
            default: nxt = 0;
        endcase
        if (m_phase != 0 && bus.abort) nxt = 0;
        if (m_phase == 2 && bus.dp_ready && !bus.abort) m_iss++;
        if (bus.res_valid) begin
            if (ok) m_ret++;
            else    m_err = 1'b1;
        end
        if (m_phase == 0 && bus.start) begin
            m_n = int'(bus.n_train); m_iss = 0; m_ret = 0; m_err = 1'b0;
        end
        m_phase = nxt;
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        res_auto = 1'b0;
        if (auto_en && cyc < 4096) res_auto = sched[cyc];
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     int'(bus.busy),     int'(m_phase != 0));
            chk("mem_rd",   int'(bus.mem_rd),   int'(m_phase == 1));
            chk("mem_addr", int'(bus.mem_addr), m_iss % (1 << NW));
            chk("dp_valid", int'(bus.dp_valid), int'(m_phase == 2));
            chk("dp_idx",   int'(bus.dp_idx),   m_iss % (1 << NW));
            chk("dp_last",  int'(bus.dp_last),  int'(m_phase == 2 && m_iss == m_n - 1));
            chk("done",     int'(bus.done),     int'(m_phase == 4));
            chk("err",      int'(bus.err),      int'(m_err));
            if (bus.mem_rd) begin
                addr_q.push_back(int'(bus.mem_addr));
                mrd_cnt++;
            end
            if (bus.dp_valid && bus.dp_idx == 1) idx1_cnt++;
            if (bus.dp_valid && bus.dp_ready) begin
                acc_cnt++;
                if (bus.dp_last) last_q.push_back(int'(bus.dp_idx));
                if (auto_en && cyc + 3 < 4096) sched[cyc+3] = 1'b1;
            end
            if (bus.done) done_cnt++;
        end
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        addr_q.delete(); last_q.delete();
        done_cnt = 0; acc_cnt = 0; mrd_cnt = 0; idx1_cnt = 0;
    endtask

    task automatic start_pass(input int n);
        bus.n_train = (NW+1)'(n);
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && bus.busy; i++) tick();
        chk("wait_idle timeout", int'(bus.busy), 0);
    endtask

    task automatic chk_addrs(input string name, input int n);
        chk({name, " addr count"}, addr_q.size(), n);
        for (int i = 0; i < n && i < addr_q.size(); i++) chk({name, " addr"}, addr_q[i], i);
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.n_train = '0; bus.dp_ready = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset busy",   int'(bus.busy),     0);
        chk("reset mem_rd", int'(bus.mem_rd),   0);
        chk("reset done",   int'(bus.done),     0);
        chk("reset err",    int'(bus.err),      0);
        chk("reset last",   int'(bus.dp_last),  0);

        // n_train=4, ready high, results 3 cycles after each accept
        clear_logs(); auto_en = 1'b1;
        start_pass(4);
        wait_idle(100);
        chk_addrs("n4", 4);
        chk("n4 last count", last_q.size(), 1);
        if (last_q.size() > 0) chk("n4 last idx", last_q[0], 3);
        chk("n4 done count", done_cnt, 1);
        chk("n4 err", int'(bus.err), 0);

        // n_train=3, 5-cycle stall on idx 1, stray start mid-pass
        clear_logs();
        start_pass(3);
        begin
            int stall = 0;
            for (int i = 0; i < 80 && bus.busy; i++) begin
                if (bus.dp_valid && bus.dp_idx == 1 && stall < 5) begin
                    bus.dp_ready = 1'b0; stall++;
                end else bus.dp_ready = 1'b1;
                bus.start   = (stall == 2);
                bus.n_train = 4'd7;
                tick();
            end
        end
        bus.start = 1'b0; bus.dp_ready = 1'b1;
        chk("stall timeout", int'(bus.busy), 0);
        chk("stall idx1 cycles", idx1_cnt, 6);
        chk("stall mem_rd count", mrd_cnt, 3);
        chk("stall accepts", acc_cnt, 3);
        chk("stall done count", done_cnt, 1);
        chk_addrs("stall", 3);

        // n_train=0
        clear_logs();
        bus.n_train = '0; bus.start = 1'b1;
        chk("n0 busy c0", int'(bus.busy), 0);
        tick(); bus.start = 1'b0;
        chk("n0 busy c1", int'(bus.busy), 1);
        chk("n0 done c1", int'(bus.done), 1);
        tick();
        chk("n0 busy c2", int'(bus.busy), 0);
        chk("n0 done c2", int'(bus.done), 0);
        chk("n0 mem_rd count", mrd_cnt, 0);
        chk("n0 done count", done_cnt, 1);

        // n_train=5, abort while issued=2, then a clean n_train=2 pass
        clear_logs();
        start_pass(5);
        for (int i = 0; i < 40 && !(bus.mem_rd && bus.mem_addr == 2); i++) tick();
        chk("abort reach fetch2", int'(bus.mem_rd), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort busy", int'(bus.busy), 0);
        chk("abort done", int'(bus.done), 0);
        repeat (6) tick();
        chk("abort done count", done_cnt, 0);
        chk("abort stray result err", int'(bus.err), 1);
        clear_logs();
        start_pass(2);
        chk("restart err cleared", int'(bus.err), 0);
        wait_idle(60);
        chk_addrs("restart", 2);
        chk("restart done count", done_cnt, 1);

        // stray results: in IDLE, then with returned == issued
        clear_logs(); auto_en = 1'b0;
        res_man = 1'b1; tick(); res_man = 1'b0;
        chk("idle res err", int'(bus.err), 1);
        start_pass(2);
        chk("start clears err", int'(bus.err), 0);
        res_man = 1'b1; tick(); res_man = 1'b0;
        chk("early res err", int'(bus.err), 1);
        repeat (3) tick();
        res_man = 1'b1; tick(); res_man = 1'b0;
        repeat (3) tick();
        chk("one result still busy", int'(bus.busy), 1);
        res_man = 1'b1; tick(); res_man = 1'b0;
        wait_idle(10);
        chk("stray done count", done_cnt, 1);
        chk("err sticky", int'(bus.err), 1);

        // full address space, then reset mid-pass
        clear_logs(); auto_en = 1'b1;
        start_pass(8);
        chk("n8 err cleared", int'(bus.err), 0);
        wait_idle(100);
        chk_addrs("n8", 8);
        chk("n8 done count", done_cnt, 1);
        chk("n8 err", int'(bus.err), 0);
        clear_logs();
        start_pass(8);
        for (int i = 0; i < 40 && !(bus.mem_rd && bus.mem_addr == 3); i++) tick();
        chk("rst reach fetch3", int'(bus.mem_rd), 1);
        rst = 1'b1;
        tick();
        chk("rst busy",     int'(bus.busy),     0);
        chk("rst mem_rd",   int'(bus.mem_rd),   0);
        chk("rst mem_addr", int'(bus.mem_addr), 0);
        chk("rst dp_valid", int'(bus.dp_valid), 0);
        chk("rst dp_idx",   int'(bus.dp_idx),   0);
        chk("rst dp_last",  int'(bus.dp_last),  0);
        chk("rst done",     int'(bus.done),     0);
        chk("rst err",      int'(bus.err),      0);
        rst = 1'b0;
        repeat (8) tick();
        chk("rst done count", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
